// File: rtl/inner_function_pkg.sv
// Shared constants and the issue tag carried alongside each operand in flight.
package inner_function_pkg;

  localparam int INNER_FUNCTION_LATENCY = 33;
  localparam int REQ_ID_W               = 1;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fallthrough FIFO; head reads as zero while empty.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {CNT_W{1'b0}});
  assign count = count_r;
  assign dout  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // A pop frees the head slot, so a push into a full FIFO is fine alongside it
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage array; contents are masked by empty, so no reset is needed
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/result_fifo_chk.sv
// Checker for one response FIFO: a result must always find a free slot.
module result_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clock,
  input logic             reset,
  input logic             push,
  input logic             pop,
  input logic             full,
  input logic [CNT_W-1:0] count
);

  // Overflow would mean the credit accounting let too many operands in
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push && full && !pop)) else $error("result_fifo overflow");
      assert (count <= CNT_W'(DEPTH)) else $error("result_fifo count out of range");
    end
  end

endmodule

// File: rtl/inner_function_arbiter.sv
// Shares one fixed-latency pipelined inner_function unit between two requesters,
// returning each result through a credit-protected per-requester FIFO.
module inner_function_arbiter
  import inner_function_pkg::*;
#(
  parameter int LATENCY    = INNER_FUNCTION_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        fu_aclr,
  output logic        fu_clk_en,
  output logic        fu_start,
  output logic [31:0] fu_dataa,
  input  logic [31:0] fu_result
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CRED_W-1:0]   CRED_MAX  = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0]   CRED_ZERO = {CRED_W{1'b0}};
  localparam logic [CRED_W-1:0]   CRED_ONE  = CRED_W'(1);
  localparam logic [REQ_ID_W-1:0] ID0       = REQ_ID_W'(0);
  localparam logic [REQ_ID_W-1:0] ID1       = REQ_ID_W'(1);

  logic [1:0]          valid_s, elig_s, grant_s, hs_s, pop_s, push_s, full_s, empty_s;
  logic [CRED_W-1:0]   credit_r [2];
  logic [CRED_W-1:0]   count0_s, count1_s;
  logic                last_grant_r;
  logic                fu_start_r;
  logic [31:0]         fu_dataa_r;
  logic [REQ_ID_W-1:0] issue_id_r;
  tag_t                tag_r [LATENCY];
  tag_t                tag_out_s;

  assign fu_aclr    = reset;
  assign fu_clk_en  = 1'b1;
  assign fu_start   = fu_start_r;
  assign fu_dataa   = fu_dataa_r;
  assign req0_ready = hs_s[0];
  assign req1_ready = hs_s[1];
  assign rsp0_valid = !empty_s[0];
  assign rsp1_valid = !empty_s[1];
  assign pop_s      = {rsp1_valid && rsp1_ready, rsp0_valid && rsp0_ready};
  assign tag_out_s  = tag_r[LATENCY-1];
  assign push_s     = {tag_out_s.valid && (tag_out_s.id == ID1),
                       tag_out_s.valid && (tag_out_s.id == ID0)};

  // Round-robin grant among requesters that hold a credit
  always_comb begin
    valid_s   = {req1_valid, req0_valid};
    elig_s[0] = valid_s[0] && (credit_r[0] != CRED_ZERO);
    elig_s[1] = valid_s[1] && (credit_r[1] != CRED_ZERO);
    grant_s   = 2'b00;
    if (elig_s == 2'b11) begin
      grant_s = last_grant_r ? 2'b01 : 2'b10;
    end else begin
      grant_s = elig_s;
    end
    hs_s = elig_s & grant_s;
  end

  // Credits: one per free response slot not already claimed by an issue
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) credit_r[i] <= CRED_MAX;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({hs_s[i], pop_s[i]})
          2'b10:   credit_r[i] <= credit_r[i] - CRED_ONE;
          2'b01:   credit_r[i] <= credit_r[i] + CRED_ONE;
          default: credit_r[i] <= credit_r[i];
        endcase
      end
    end
  end

  // Issue register and round-robin history; operand holds when idle
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= 1'b1;
      fu_start_r   <= 1'b0;
      fu_dataa_r   <= 32'h0000_0000;
      issue_id_r   <= ID0;
    end else begin
      fu_start_r <= |hs_s;
      if (hs_s[0]) begin
        last_grant_r <= 1'b0;
        fu_dataa_r   <= req0_data;
        issue_id_r   <= ID0;
      end else if (hs_s[1]) begin
        last_grant_r <= 1'b1;
        fu_dataa_r   <= req1_data;
        issue_id_r   <= ID1;
      end
    end
  end

  // Tag travels beside the unit so it leaves exactly when fu_result is valid
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) tag_r[i] <= '{valid: 1'b0, id: ID0};
    end else begin
      tag_r[0] <= '{valid: fu_start_r, id: issue_id_r};
      for (int i = 1; i < LATENCY; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo0 (
    .clock(clock), .reset(reset), .push(push_s[0]), .din(fu_result), .pop(pop_s[0]),
    .dout(rsp0_data), .full(full_s[0]), .empty(empty_s[0]), .count(count0_s)
  );

  result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo1 (
    .clock(clock), .reset(reset), .push(push_s[1]), .din(fu_result), .pop(pop_s[1]),
    .dout(rsp1_data), .full(full_s[1]), .empty(empty_s[1]), .count(count1_s)
  );

  result_fifo_chk #(.DEPTH(FIFO_DEPTH), .CNT_W(CRED_W)) u_chk0 (
    .clock(clock), .reset(reset), .push(push_s[0]), .pop(pop_s[0]),
    .full(full_s[0]), .count(count0_s)
  );

  result_fifo_chk #(.DEPTH(FIFO_DEPTH), .CNT_W(CRED_W)) u_chk1 (
    .clock(clock), .reset(reset), .push(push_s[1]), .pop(pop_s[1]),
    .full(full_s[1]), .count(count1_s)
  );

endmodule

// File: tb/tb_inner_function_arbiter.sv
// Directed bench for inner_function_arbiter with a behavioural unit model f(x) = x + 0x00010000.
module tb_inner_function_arbiter;

  localparam int LAT   = 33;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        fu_aclr, fu_clk_en, fu_start;
  logic [31:0] fu_dataa, fu_result;

  logic        f_push, f_pop, f_full, f_empty;
  logic [31:0] f_din, f_dout;
  logic [2:0]  f_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] pipe [LAT];
  logic [31:0] d0 [3] = '{32'h3f800000, 32'h40000000, 32'h40400000};
  logic [31:0] d1 [3] = '{32'h41000000, 32'h41100000, 32'h41200000};
  logic [31:0] e0 [3] = '{32'h3f810000, 32'h40010000, 32'h40410000};
  logic [31:0] e1 [3] = '{32'h41010000, 32'h41110000, 32'h41210000};
  logic [31:0] fv [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

  always #5 clock = ~clock;

  // Behavioural unit: fixed latency, garbage when no start
  always @(posedge clock) begin
    if (fu_aclr) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= 32'hdeadbeef;
    end else begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= fu_start ? (fu_dataa + 32'h00010000) : 32'hdeadbeef;
    end
  end
  assign fu_result = pipe[LAT-1];

  inner_function_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .fu_aclr(fu_aclr), .fu_clk_en(fu_clk_en), .fu_start(fu_start),
    .fu_dataa(fu_dataa), .fu_result(fu_result)
  );

  result_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clock(clock), .reset(reset), .push(f_push), .din(f_din), .pop(f_pop),
    .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, hs0, hs1, r0, r1;
    logic seen;

    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 32'h0; req1_data = 32'h0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    f_push = 1'b0; f_pop = 1'b0; f_din = 32'h0;
    tick(); tick(); tick();
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp1_data", rsp1_data, 32'd0);
    chk("rst_fu_start", 32'(fu_start), 32'd0);
    chk("rst_fu_dataa", fu_dataa, 32'd0);
    chk("rst_fu_clk_en", 32'(fu_clk_en), 32'd1);
    chk("rst_fu_aclr", 32'(fu_aclr), 32'd1);
    reset = 1'b0;
    tick();
    chk("aclr_low", 32'(fu_aclr), 32'd0);

    // Standalone FIFO: pop-empty, fill, push+pop at full, drain order
    chk("fifo_empty", 32'(f_empty), 32'd1);
    f_pop = 1'b1; tick(); f_pop = 1'b0;
    chk("fifo_pop_empty_count", 32'(f_count), 32'd0);
    f_push = 1'b1;
    for (int i = 0; i < 4; i++) begin f_din = fv[i]; tick(); end
    chk("fifo_full", 32'(f_full), 32'd1);
    chk("fifo_head", f_dout, 32'h11);
    f_din = fv[4]; f_pop = 1'b1; tick();
    f_push = 1'b0;
    chk("fifo_pushpop_full_count", 32'(f_count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("fifo_order%0d", i), f_dout, fv[i]);
      tick();
    end
    f_pop = 1'b0;
    chk("fifo_drained", 32'(f_empty), 32'd1);

    // Single op on requester 0
    req0_valid = 1'b1; req0_data = 32'h3f800000; #1;
    chk("single_ready0", 32'(req0_ready), 32'd1);
    chk("single_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("single_start", 32'(fu_start), 32'd1);
    chk("single_dataa", fu_dataa, 32'h3f800000);
    n = 1; seen = 1'b0;
    while (!rsp0_valid && n < 80) begin
      tick(); n++;
      if (n == 2) begin
        chk("single_start_drop", 32'(fu_start), 32'd0);
        chk("single_dataa_hold", fu_dataa, 32'h3f800000);
      end
      if (rsp1_valid) seen = 1'b1;
    end
    chk("single_latency", n, 32'd35);
    chk("single_data", rsp0_data, 32'h3f810000);
    chk("single_no_rsp1", 32'(seen), 32'd0);
    rsp0_ready = 1'b1; tick(); rsp0_ready = 1'b0;
    chk("single_popped", 32'(rsp0_valid), 32'd0);

    // Contention and per-port ordering
    reset = 1'b1; tick(); reset = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1; hs0 = 0; hs1 = 0;
    for (int k = 0; k < 6; k++) begin
      req0_valid = (hs0 < 3); req0_data = d0[(hs0 < 3) ? hs0 : 2];
      req1_valid = (hs1 < 3); req1_data = d1[(hs1 < 3) ? hs1 : 2];
      #1;
      chk($sformatf("cont_grant0_%0d", k), 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont_grant1_%0d", k), 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      if (req0_ready) hs0++;
      if (req1_ready) hs1++;
      tick();
      chk($sformatf("cont_start_%0d", k), 32'(fu_start), 32'd1);
      chk($sformatf("cont_dataa_%0d", k), fu_dataa, (k % 2 == 0) ? d0[k/2] : d1[k/2]);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    r0 = 0; r1 = 0;
    for (int c = 0; c < 60; c++) begin
      if (rsp0_valid) begin
        if (r0 < 3) chk($sformatf("ord0_%0d", r0), rsp0_data, e0[r0]);
        r0++;
      end
      if (rsp1_valid) begin
        if (r1 < 3) chk($sformatf("ord1_%0d", r1), rsp1_data, e1[r1]);
        r1++;
      end
      tick();
    end
    chk("ord0_count", r0, 32'd3);
    chk("ord1_count", r1, 32'd3);

    // Credit stall on requester 0
    reset = 1'b1; tick(); reset = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h40a00000; #1;
    hs0 = 0;
    for (int c = 0; c < 10; c++) begin
      if (req0_ready) hs0++;
      tick();
    end
    chk("stall_hs", hs0, 32'd4);
    chk("stall_ready_low", 32'(req0_ready), 32'd0);
    n = 0;
    while (!rsp0_valid && n < 60) begin
      if (req0_ready) hs0++;
      tick(); n++;
    end
    chk("stall_rsp_arrived", 32'(rsp0_valid), 32'd1);
    chk("stall_hs_still", hs0, 32'd4);
    rsp0_ready = 1'b1; #1;
    if (req0_ready) hs0++;
    tick();
    rsp0_ready = 1'b0; #1;
    for (int c = 0; c < 10; c++) begin
      if (req0_ready) hs0++;
      tick();
    end
    chk("stall_refill_hs", hs0, 32'd5);

    // Credit return and accept together leave the credit unchanged
    rsp0_ready = 1'b1; #1;
    chk("simul_a_ready", 32'(req0_ready), 32'd0);
    tick();
    chk("simul_b_ready", 32'(req0_ready), 32'd1);
    tick();
    chk("simul_credit_kept", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0;
    for (int c = 0; c < 45; c++) tick();
    rsp0_ready = 1'b0; req0_valid = 1'b1; #1;
    hs0 = 0;
    for (int c = 0; c < 10; c++) begin
      if (req0_ready) hs0++;
      tick();
    end
    chk("credit_restored", hs0, 32'd4);
    req0_valid = 1'b0;

    // Reset with three ops in flight
    reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h3f800000; tick();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 32'h41000000; tick();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 32'h40000000; tick();
    req0_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      if (rsp0_valid || rsp1_valid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("midrst_first_grant0", 32'(req0_ready), 32'd1);
    chk("midrst_first_grant1", 32'(req1_ready), 32'd0);
    hs0 = 0; hs1 = 0;
    for (int c = 0; c < 14; c++) begin
      if (req0_ready) hs0++;
      if (req1_ready) hs1++;
      tick();
    end
    chk("midrst_credit0", hs0, 32'd4);
    chk("midrst_credit1", hs1, 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
